tanh_pwl_eval: RTL
==================

Name: tanh_pwl_eval

Overview:
- Pipelined piecewise-linear tanh evaluator; it is the reader side of the team's 16-entry tanh LUT interface (4-bit address in; base and next_data out).
- Drives the LUT address and consumes the LUT's combinational base/next_data.
- Linearly interpolates between the two samples using the low input bits.
- Sits between an MLP neuron accumulator output and the next layer, with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 8, width of signed input x, LUT samples and output y.
- ADDR_WIDTH, 4, LUT address width; taken from x[DATA_WIDTH-1 -: ADDR_WIDTH].
- FRAC_BITS, 4, interpolation fraction width; equals DATA_WIDTH-ADDR_WIDTH, taken from x[FRAC_BITS-1:0].

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  x is valid.
- in_ready  out  1  block accepts x this cycle.
- in_x  in  DATA_WIDTH  signed input sample.
- lut_address  out  ADDR_WIDTH  address to tanh LUT.
- lut_base  in  DATA_WIDTH  signed LUT sample at lut_address (combinational return).
- lut_next_data  in  DATA_WIDTH  signed LUT next sample, combinational return. The LUT supplies:
  - entry+1 in general;
  - entry 0 for address 15;
  - entry 7 for address 7.
- out_valid  out  1  out_y is valid.
- out_ready  in  1  downstream accepts out_y.
- out_y  out  DATA_WIDTH  signed interpolated tanh.

Behaviour:
- Reset (async assert, sync-release usage):
  - s1_valid, s2_valid and s3_valid (out_valid) clear to 0.
  - out_y = 0, lut_address = 0, all data registers = 0.
- Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational, no dependency on in_valid).
- When adv=0, every stage holds, including out_y and lut_address.
- Stage 1, on adv:
  - s1_valid <= in_valid;
  - if in_valid: s1_addr <= in_x[7:4], s1_frac <= in_x[3:0].
  - lut_address = s1_addr (registered, stable for a full cycle).
- Stage 2, on adv:
  - s2_valid <= s1_valid;
  - s2_base <= lut_base;
  - s2_delta <= lut_next_data - lut_base, computed at DATA_WIDTH+1 bits signed;
  - s2_frac <= s1_frac.
- Stage 3, on adv:
  - s3_valid <= s2_valid.
  - prod = s2_delta * $signed({1'b0,s2_frac}), DATA_WIDTH+FRAC_BITS+1 bits.
  - corr = (prod + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift; round half toward +inf).
  - sum = s2_base + corr at DATA_WIDTH+2 bits, saturated to [-128,127].
  - out_y <= saturated sum.
- Latency: handshake at edge N -> out_valid high after edge N+2 with no stall. Throughput: 1 sample/cycle.
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages. Data registers of invalid stages are don't-care, except out_y, which holds its last valid value.
- Back-pressure: out_valid=1 and out_ready=0 -> in_ready=0.
  - Nothing is lost or duplicated; out_y is stable until accepted.
- Simultaneous out handshake and in handshake in the same cycle: both complete, pipeline shifts.
- Address wrap: x=0xF0..0xFF uses address 15, whose next sample is entry 0. The block relies on the LUT for this and applies no special case.
- Reset mid-stream: all in-flight samples are discarded; out_valid drops immediately on rst_n low.

Decomposition:
- Shared package tanh_pkg:
  - DATA_WIDTH, ADDR_WIDTH, FRAC_BITS localparams;
  - a sat_to_data function (saturating narrow to DATA_WIDTH);
  - the LUT sample constants, for bench golden model use.
- No sub-module inside the evaluator. The LUT stays external; the top level wires lut_address, lut_base and lut_next_data to the existing LUT block.
- Bench instantiates the evaluator plus the LUT with contents:
  - entry 0 = 0, entry 1 = 12;
  - entries 2..7 = 15;
  - entries 8..14 = -15;
  - entry 15 = -12.

Test Plan:
- Single samples, out_ready=1, each separated by idle cycles:
  - x=0x08 -> y=6;
  - x=0x10 -> y=12;
  - x=0x18 -> y=14;
  - x=0x7F -> y=15;
  - x=0x80 -> y=-15.
  - Each out_valid pulse appears exactly 3 cycles after acceptance.
- Wrap: x=0xF8 -> y=-6 (base -12, next 0); x=0xFF -> y=-1.
- Back-to-back stream 0x00,0x08,0x10,0x18 with out_ready=1 -> outputs 0,6,12,14 on consecutive cycles, no gaps.
- Stream of 6 samples with out_ready low for 4 cycles mid-stream:
  - in_ready low during the stall;
  - out_y held;
  - all 6 results emitted in order, none duplicated.
- Assert rst_n low while 3 samples are in flight:
  - out_valid=0 and out_y=0 immediately;
  - after release, next sample x=0x08 -> y=6 with normal latency.
- Sweep all 256 x with random in_valid and out_ready -> every out_y matches the tanh_pkg golden model. Bench also asserts lut_address only changes on adv cycles.

Source files
------------

// File: rtl/tanh_pkg.sv
// Shared constants and helpers for the piecewise-linear tanh datapath and its LUT.
package tanh_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned FRAC_BITS  = DATA_WIDTH - ADDR_WIDTH;

  // Narrow a DATA_WIDTH+2 bit signed value to DATA_WIDTH bits, clamping at the rails.
  function automatic logic signed [DATA_WIDTH-1:0] sat_to_data(
    input logic signed [DATA_WIDTH+1:0] v
  );
    logic [2:0] top;
    top = v[DATA_WIDTH+1:DATA_WIDTH-1];
    if (top == 3'b000 || top == 3'b111) begin
      return v[DATA_WIDTH-1:0];
    end else if (v[DATA_WIDTH+1]) begin
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  endfunction

  // Contents of the team's 16-entry tanh sample table.
  function automatic logic signed [DATA_WIDTH-1:0] tanh_lut_entry(
    input logic [ADDR_WIDTH-1:0] idx
  );
    if (idx == 4'd0) begin
      return 8'sd0;
    end else if (idx == 4'd1) begin
      return 8'sd12;
    end else if (idx <= 4'd7) begin
      return 8'sd15;
    end else if (idx <= 4'd14) begin
      return -8'sd15;
    end else begin
      return -8'sd12;
    end
  endfunction

endpackage

// File: rtl/tanh_pwl_eval.sv
// Three-stage piecewise-linear tanh evaluator: address/fraction capture, LUT sample
// capture with slope, then interpolate-round-saturate. One global advance stalls all stages.
module tanh_pwl_eval
  import tanh_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_x,
  output logic [ADDR_WIDTH-1:0]        lut_address,
  input  logic signed [DATA_WIDTH-1:0] lut_base,
  input  logic signed [DATA_WIDTH-1:0] lut_next_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_y
);

  localparam int unsigned DeltaW = DATA_WIDTH + 1;
  localparam int unsigned ProdW  = DATA_WIDTH + FRAC_BITS + 1;
  localparam int unsigned SumW   = DATA_WIDTH + 2;
  localparam logic signed [ProdW-1:0] RoundHalf = ProdW'(1) << (FRAC_BITS - 1);

  logic                         adv;
  logic                         s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0]        s1_addr_q, s1_addr_d;
  logic [FRAC_BITS-1:0]         s1_frac_q, s1_frac_d;
  logic                         s2_valid_q, s2_valid_d;
  logic signed [DATA_WIDTH-1:0] s2_base_q, s2_base_d;
  logic signed [DeltaW-1:0]     s2_delta_q, s2_delta_d;
  logic [FRAC_BITS-1:0]         s2_frac_q, s2_frac_d;
  logic                         s3_valid_q, s3_valid_d;
  logic signed [DATA_WIDTH-1:0] out_y_q, out_y_d;
  logic signed [ProdW-1:0]      prod;
  logic signed [ProdW-1:0]      prod_rnd;
  logic signed [SumW-1:0]       sum;

  assign adv         = !s3_valid_q || out_ready;
  assign in_ready    = adv;
  assign lut_address = s1_addr_q;
  assign out_valid   = s3_valid_q;
  assign out_y       = out_y_q;

  // Interpolation arithmetic on the stage-2 registers.
  always_comb begin
    prod     = ProdW'(s2_delta_q) * ProdW'($signed({1'b0, s2_frac_q}));
    prod_rnd = prod + RoundHalf;
    sum      = SumW'(s2_base_q) + SumW'(prod_rnd >>> FRAC_BITS);
  end

  // Next-state for all stages; everything holds while adv is low.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    s1_frac_d  = s1_frac_q;
    s2_valid_d = s2_valid_q;
    s2_base_d  = s2_base_q;
    s2_delta_d = s2_delta_q;
    s2_frac_d  = s2_frac_q;
    s3_valid_d = s3_valid_q;
    out_y_d    = out_y_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_addr_d = in_x[DATA_WIDTH-1 -: ADDR_WIDTH];
        s1_frac_d = in_x[FRAC_BITS-1:0];
      end
      s2_valid_d = s1_valid_q;
      s2_base_d  = lut_base;
      s2_delta_d = DeltaW'(lut_next_data) - DeltaW'(lut_base);
      s2_frac_d  = s1_frac_q;
      s3_valid_d = s2_valid_q;
      // Bubbles leave the last delivered result on out_y.
      if (s2_valid_q) begin
        out_y_d = sat_to_data(sum);
      end
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_frac_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_base_q  <= '0;
      s2_delta_q <= '0;
      s2_frac_q  <= '0;
      s3_valid_q <= 1'b0;
      out_y_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_frac_q  <= s1_frac_d;
      s2_valid_q <= s2_valid_d;
      s2_base_q  <= s2_base_d;
      s2_delta_q <= s2_delta_d;
      s2_frac_q  <= s2_frac_d;
      s3_valid_q <= s3_valid_d;
      out_y_q    <= out_y_d;
    end
  end

endmodule
